multicycle_control: RTL and testbench

//  Multi-cycle MIPS main control FSM; successor to the single-cycle opcode decoder.

---
 rtl/multicycle_control_pkg.sv | 28 ++
 rtl/multicycle_control_if.sv | 36 +++
 rtl/multicycle_control_mem_wait_timer.sv | 37 +++
 rtl/multicycle_control.sv | 135 +++++++++++++
 tb/tb_multicycle_control.sv | 284 ++++++++++++++++++++++++++++
 5 files changed

// File: rtl/multicycle_control_pkg.sv
// Shared types for the multi-cycle MIPS control FSM: state encoding, opcodes
// and the datapath mux/ALU select encodings.
package multicycle_control_pkg;

  typedef enum logic [3:0] {
    S_IDLE, S_FETCH, S_DECODE, S_EXEC_R, S_WB_R, S_EXEC_I, S_WB_I, S_ADDR,
    S_MEM_RD, S_WB_MEM, S_MEM_WR, S_BRANCH, S_JUMP, S_ILLEGAL, S_ERROR, S_HALT
  } state_e;

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_J     = 6'b000010;

  typedef enum logic [1:0] {ALU_ADD = 2'b00, ALU_SUB = 2'b01, ALU_FUNCT = 2'b10} alu_op_e;
  typedef enum logic [1:0] {
    SRCB_RT = 2'b00, SRCB_FOUR = 2'b01, SRCB_IMM = 2'b10, SRCB_IMM_SH2 = 2'b11
  } alu_src_b_e;
  typedef enum logic [1:0] {PCSRC_ALU = 2'b00, PCSRC_ALUOUT = 2'b01, PCSRC_JUMP = 2'b10} pc_source_e;

  // States that hold a memory access open and therefore run the wait timer.
  function automatic logic is_wait_state(state_e s);
    return (s == S_FETCH) || (s == S_MEM_RD) || (s == S_MEM_WR);
  endfunction

endpackage

// File: rtl/multicycle_control_if.sv
// Control bus between the multi-cycle control FSM (master) and the datapath
// plus shared memory (slave).
interface multicycle_control_if;
  logic [5:0] Op_i;
  logic       MemReady_i;
  logic       PCWrite_o;
  logic       PCWriteCond_o;
  logic       IorD_o;
  logic       MemRead_o;
  logic       MemWrite_o;
  logic       IRWrite_o;
  logic       MemToReg_o;
  logic       RegDst_o;
  logic       RegWrite_o;
  logic       ALUSrcA_o;
  logic [1:0] ALUSrcB_o;
  logic [1:0] ALUOp_o;
  logic [1:0] PCSource_o;
  logic       IllegalOp_o;
  logic       BusErr_o;
  logic       Halt_o;

  modport master (
    input  Op_i, MemReady_i,
    output PCWrite_o, PCWriteCond_o, IorD_o, MemRead_o, MemWrite_o, IRWrite_o,
           MemToReg_o, RegDst_o, RegWrite_o, ALUSrcA_o, ALUSrcB_o, ALUOp_o,
           PCSource_o, IllegalOp_o, BusErr_o, Halt_o
  );

  modport slave (
    output Op_i, MemReady_i,
    input  PCWrite_o, PCWriteCond_o, IorD_o, MemRead_o, MemWrite_o, IRWrite_o,
           MemToReg_o, RegDst_o, RegWrite_o, ALUSrcA_o, ALUSrcB_o, ALUOp_o,
           PCSource_o, IllegalOp_o, BusErr_o, Halt_o
  );
endinterface

// File: rtl/multicycle_control_mem_wait_timer.sv
// Counts not-ready cycles of the open memory access; flags a timeout when the
// count has reached TIMEOUT and memory is still not ready (0 disables it).
module multicycle_control_mem_wait_timer #(
  parameter int unsigned TIMEOUT = 16
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic busy_i,
  input  logic ready_i,
  input  logic clear_i,
  output logic timeout_o
);
  localparam int unsigned   CW    = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT + 1);
  localparam logic [CW-1:0] LIMIT = CW'(TIMEOUT);

  logic [CW-1:0] count_q, count_d;

  // NOTE: the combinational block assigns its output before any branch, so no latch is inferred.
  always_comb begin
    count_d = count_q;
    if (clear_i) begin
      count_d = '0;
    end else if (busy_i && !ready_i && (TIMEOUT != 0)) begin
      count_d = count_q + CW'(1);
    end
  end

  // NOTE: state is updated with non-blocking assignments so all flops sample pre-edge values.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) count_q <= '0;
    else       count_q <= count_d;
  end

  // A ready in the cycle the limit is reached completes the access instead.
  assign timeout_o = (TIMEOUT != 0) && busy_i && !ready_i && (count_q == LIMIT);

endmodule

// File: rtl/multicycle_control.sv
// Multi-cycle MIPS main control FSM: sequences fetch/decode/execute/memory/
// writeback over a shared memory with ready handshake, illegal-op trap and bus timeout.
module multicycle_control
  import multicycle_control_pkg::*;
#(
  parameter int unsigned TIMEOUT      = 16,
  parameter bit          ILLEGAL_HALT = 1'b0,
  parameter bit          ENABLE_JUMP  = 1'b1
) (
  input  logic                clk_i,
  input  logic                rst_i,
  multicycle_control_if.master bus
);
  state_e state_q, state_d;
  logic   bus_err_q, bus_err_d;
  logic   busy, timeout, state_change;

  assign busy         = is_wait_state(state_q);
  assign state_change = (state_d != state_q);

  multicycle_control_mem_wait_timer #(.TIMEOUT(TIMEOUT)) u_timer (
    .clk_i     (clk_i),
    .rst_i     (rst_i),
    .busy_i    (busy),
    .ready_i   (bus.MemReady_i),
    .clear_i   (state_change),
    .timeout_o (timeout)
  );

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q   <= S_IDLE;
      bus_err_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      bus_err_q <= bus_err_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    bus_err_d = bus_err_q | timeout;
    unique case (state_q)
      S_IDLE:   state_d = S_FETCH;
      S_FETCH:  if (bus.MemReady_i) state_d = S_DECODE; else if (timeout) state_d = S_ERROR;
      S_DECODE: begin
        case (bus.Op_i)
          OP_RTYPE:     state_d = S_EXEC_R;
          OP_ADDI:      state_d = S_EXEC_I;
          OP_LW, OP_SW: state_d = S_ADDR;
          OP_BEQ:       state_d = S_BRANCH;
          OP_J:         state_d = ENABLE_JUMP ? S_JUMP : S_ILLEGAL;
          default:      state_d = S_ILLEGAL;
        endcase
      end
      S_EXEC_R: state_d = S_WB_R;
      S_EXEC_I: state_d = S_WB_I;
      S_ADDR:   state_d = (bus.Op_i == OP_LW) ? S_MEM_RD : S_MEM_WR;
      S_MEM_RD: if (bus.MemReady_i) state_d = S_WB_MEM; else if (timeout) state_d = S_ERROR;
      S_MEM_WR: if (bus.MemReady_i) state_d = S_FETCH;  else if (timeout) state_d = S_ERROR;
      S_WB_R, S_WB_I, S_WB_MEM, S_BRANCH, S_JUMP: state_d = S_FETCH;
      S_ILLEGAL: state_d = ILLEGAL_HALT ? S_HALT : S_FETCH;
      S_ERROR:   state_d = S_HALT;
      S_HALT:    state_d = S_HALT;
    endcase
  end

  // Moore decode; only the FETCH IR/PC load waits on the ready handshake.
  always_comb begin
    bus.PCWrite_o     = 1'b0;
    bus.PCWriteCond_o = 1'b0;
    bus.IorD_o        = 1'b0;
    bus.MemRead_o     = 1'b0;
    bus.MemWrite_o    = 1'b0;
    bus.IRWrite_o     = 1'b0;
    bus.MemToReg_o    = 1'b0;
    bus.RegDst_o      = 1'b0;
    bus.RegWrite_o    = 1'b0;
    bus.ALUSrcA_o     = 1'b0;
    bus.ALUSrcB_o     = SRCB_RT;
    bus.ALUOp_o       = ALU_ADD;
    bus.PCSource_o    = PCSRC_ALU;
    bus.IllegalOp_o   = 1'b0;
    bus.BusErr_o      = bus_err_q;
    bus.Halt_o        = 1'b0;
    unique case (state_q)
      S_FETCH: begin
        bus.MemRead_o = 1'b1;
        bus.ALUSrcB_o = SRCB_FOUR;
        bus.IRWrite_o = bus.MemReady_i;
        bus.PCWrite_o = bus.MemReady_i;
      end
      S_DECODE: bus.ALUSrcB_o = SRCB_IMM_SH2;
      S_EXEC_R: begin
        bus.ALUSrcA_o = 1'b1;
        bus.ALUOp_o   = ALU_FUNCT;
      end
      S_WB_R: begin
        bus.RegDst_o   = 1'b1;
        bus.RegWrite_o = 1'b1;
      end
      S_EXEC_I, S_ADDR: begin
        bus.ALUSrcA_o = 1'b1;
        bus.ALUSrcB_o = SRCB_IMM;
      end
      S_WB_I: bus.RegWrite_o = 1'b1;
      S_MEM_RD: begin
        bus.MemRead_o = 1'b1;
        bus.IorD_o    = 1'b1;
      end
      S_WB_MEM: begin
        bus.MemToReg_o = 1'b1;
        bus.RegWrite_o = 1'b1;
      end
      S_MEM_WR: begin
        bus.MemWrite_o = 1'b1;
        bus.IorD_o     = 1'b1;
      end
      S_BRANCH: begin
        bus.ALUSrcA_o     = 1'b1;
        bus.ALUOp_o       = ALU_SUB;
        bus.PCWriteCond_o = 1'b1;
        bus.PCSource_o    = PCSRC_ALUOUT;
      end
      S_JUMP: begin
        bus.PCWrite_o  = 1'b1;
        bus.PCSource_o = PCSRC_JUMP;
      end
      S_ILLEGAL: bus.IllegalOp_o = 1'b1;
      S_HALT:    bus.Halt_o      = 1'b1;
      default: ;
    endcase
  end

endmodule

// File: tb/tb_multicycle_control.sv
// Self-checking bench: builds per-cycle expectations from instruction-level
// rules (phases, wait counts, timeout arithmetic) and compares two DUT configs.
module tb_multicycle_control;

  typedef struct packed {
    logic       pc_write, pc_write_cond, iord, mem_read, mem_write, ir_write;
    logic       mem_to_reg, reg_dst, reg_write, src_a;
    logic [1:0] src_b, alu_op, pc_source;
    logic       illegal, bus_err, halt;
  } vec_t;

  localparam vec_t V_ZERO       = '0;
  localparam vec_t V_FETCH_WAIT = '{mem_read: 1'b1, src_b: 2'b01, default: '0};
  localparam vec_t V_FETCH_DONE = '{mem_read: 1'b1, src_b: 2'b01, ir_write: 1'b1, pc_write: 1'b1, default: '0};
  localparam vec_t V_DECODE     = '{src_b: 2'b11, default: '0};
  localparam vec_t V_EXEC_R     = '{src_a: 1'b1, alu_op: 2'b10, default: '0};
  localparam vec_t V_WB_R       = '{reg_dst: 1'b1, reg_write: 1'b1, default: '0};
  localparam vec_t V_EXEC_I     = '{src_a: 1'b1, src_b: 2'b10, default: '0};
  localparam vec_t V_WB_I       = '{reg_write: 1'b1, default: '0};
  localparam vec_t V_MEM_RD     = '{mem_read: 1'b1, iord: 1'b1, default: '0};
  localparam vec_t V_WB_MEM     = '{mem_to_reg: 1'b1, reg_write: 1'b1, default: '0};
  localparam vec_t V_MEM_WR     = '{mem_write: 1'b1, iord: 1'b1, default: '0};
  localparam vec_t V_BRANCH     = '{src_a: 1'b1, alu_op: 2'b01, pc_write_cond: 1'b1, pc_source: 2'b01, default: '0};
  localparam vec_t V_JUMP       = '{pc_write: 1'b1, pc_source: 2'b10, default: '0};
  localparam vec_t V_ILLEGAL    = '{illegal: 1'b1, default: '0};
  localparam vec_t V_ERROR      = '{bus_err: 1'b1, default: '0};

  logic       clk = 1'b0;
  logic       rst_a, rst_b;
  logic [5:0] op;
  logic       rdy;
  int         sel;
  int         vectors = 0;
  int         miscompares = 0;

  always #5 clk = ~clk;

  multicycle_control_if if_a ();
  multicycle_control_if if_b ();

  assign if_a.Op_i = op;
  assign if_a.MemReady_i = rdy;
  assign if_b.Op_i = op;
  assign if_b.MemReady_i = rdy;

  multicycle_control #(.TIMEOUT(4), .ILLEGAL_HALT(1'b0), .ENABLE_JUMP(1'b0)) dut_a (
    .clk_i(clk), .rst_i(rst_a), .bus(if_a)
  );
  multicycle_control #(.TIMEOUT(0), .ILLEGAL_HALT(1'b1), .ENABLE_JUMP(1'b1)) dut_b (
    .clk_i(clk), .rst_i(rst_b), .bus(if_b)
  );

  vec_t act_a, act_b;
  assign act_a = {if_a.PCWrite_o, if_a.PCWriteCond_o, if_a.IorD_o, if_a.MemRead_o, if_a.MemWrite_o,
                  if_a.IRWrite_o, if_a.MemToReg_o, if_a.RegDst_o, if_a.RegWrite_o, if_a.ALUSrcA_o,
                  if_a.ALUSrcB_o, if_a.ALUOp_o, if_a.PCSource_o, if_a.IllegalOp_o, if_a.BusErr_o, if_a.Halt_o};
  assign act_b = {if_b.PCWrite_o, if_b.PCWriteCond_o, if_b.IorD_o, if_b.MemRead_o, if_b.MemWrite_o,
                  if_b.IRWrite_o, if_b.MemToReg_o, if_b.RegDst_o, if_b.RegWrite_o, if_b.ALUSrcA_o,
                  if_b.ALUSrcB_o, if_b.ALUOp_o, if_b.PCSource_o, if_b.IllegalOp_o, if_b.BusErr_o, if_b.Halt_o};

  function automatic vec_t cur();
    return (sel == 0) ? act_a : act_b;
  endfunction

  // Per-cycle schedule: inputs to drive, expected outputs, reset marker.
  logic [5:0] s_op[$];
  logic       s_rdy[$];
  vec_t       s_exp[$];
  bit         s_rst[$];

  // Model configuration and architectural flags.
  int unsigned m_timeout;
  bit          m_ill_halt, m_en_jump, m_halted, m_bus_err;

  function automatic logic [5:0] rnd_op();
    return 6'($urandom_range(0, 63));
  endfunction

  function automatic logic rb();
    return 1'($urandom_range(0, 1));
  endfunction

  task automatic check(input string name, input int idx, input vec_t got, input vec_t exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s[%0d]: got %05h expected %05h", name, idx, got, exp);
    end
  endtask

  task automatic check_int(input string name, input int got, input int exp);
    vectors++;
    if (got != exp) begin
      miscompares++;
      $display("FAIL %s: got %0d expected %0d", name, got, exp);
    end
  endtask

  task automatic push(input logic [5:0] o, input logic r, input vec_t v, input bit rs = 1'b0);
    s_op.push_back(o);
    s_rdy.push_back(r);
    s_exp.push_back(v);
    s_rst.push_back(rs);
  endtask

  task automatic add_reset();
    push(rnd_op(), rb(), V_ZERO, 1'b1);
    m_halted  = 1'b0;
    m_bus_err = 1'b0;
  endtask

  task automatic add_halt_cycles(input int n);
    vec_t v;
    v = '{halt: 1'b1, bus_err: m_bus_err, default: '0};
    repeat (n) push(rnd_op(), rb(), v);
  endtask

  // One memory access with `waits` not-ready cycles; past the limit it becomes a bus error.
  task automatic mem_phase(input logic [5:0] o, input int waits, input vec_t v_wait,
                           input vec_t v_done, output bit ok);
    if (m_timeout != 0 && waits > int'(m_timeout)) begin
      repeat (m_timeout + 1) push(o, 1'b0, v_wait);
      push(rnd_op(), rb(), V_ERROR);
      m_bus_err = 1'b1;
      m_halted  = 1'b1;
      ok = 1'b0;
    end else begin
      repeat (waits) push(o, 1'b0, v_wait);
      push(o, 1'b1, v_done);
      ok = 1'b1;
    end
  endtask

  task automatic add_instr(input logic [5:0] o, input int wf, input int wm, input bit abort_mem = 1'b0);
    bit ok;
    if (m_halted) return;
    mem_phase(rnd_op(), wf, V_FETCH_WAIT, V_FETCH_DONE, ok);
    if (!ok) return;
    push(o, rb(), V_DECODE);
    if (o == 6'd0) begin
      push(o, rb(), V_EXEC_R);
      push(o, rb(), V_WB_R);
    end else if (o == 6'd8) begin
      push(o, rb(), V_EXEC_I);
      push(o, rb(), V_WB_I);
    end else if (o == 6'd35) begin
      push(o, rb(), V_EXEC_I);
      mem_phase(o, wm, V_MEM_RD, V_MEM_RD, ok);
      if (ok) push(o, rb(), V_WB_MEM);
    end else if (o == 6'd43) begin
      push(o, rb(), V_EXEC_I);
      if (abort_mem) begin
        repeat (wm) push(o, 1'b0, V_MEM_WR);
        add_reset();
      end else begin
        mem_phase(o, wm, V_MEM_WR, V_MEM_WR, ok);
      end
    end else if (o == 6'd4) begin
      push(o, rb(), V_BRANCH);
    end else if (o == 6'd2 && m_en_jump) begin
      push(o, rb(), V_JUMP);
    end else begin
      push(o, rb(), V_ILLEGAL);
      if (m_ill_halt) m_halted = 1'b1;
    end
  endtask

  function automatic logic [5:0] pick_op();
    case ($urandom_range(0, 7))
      0: return 6'd0;
      1: return 6'd8;
      2: return 6'd35;
      3: return 6'd43;
      4: return 6'd4;
      5: return 6'd2;
      default: return rnd_op();
    endcase
  endfunction

  function automatic int pick_wait();
    return ($urandom_range(0, 5) == 0) ? int'($urandom_range(4, 6)) : int'($urandom_range(0, 3));
  endfunction

  task automatic add_random(input int n);
    for (int i = 0; i < n; i++) begin
      if (m_halted) begin
        add_halt_cycles(3);
        add_reset();
      end else begin
        add_instr(pick_op(), pick_wait(), pick_wait());
      end
    end
  endtask

  task automatic lat(input string name, input logic [5:0] o, input int exp);
    int n0;
    n0 = s_exp.size();
    add_instr(o, 0, 0);
    check_int(name, s_exp.size() - n0, exp);
  endtask

  task automatic run_schedule();
    for (int k = 0; k < s_exp.size(); k++) begin
      @(posedge clk);
      #1;
      op  = s_op[k];
      rdy = s_rdy[k];
      if (s_rst[k]) begin
        if (sel == 0) rst_a = 1'b1; else rst_b = 1'b1;
        #1;
        check("async_rst", k, cur(), V_ZERO);
      end
      @(negedge clk);
      check("cycle", k, cur(), s_exp[k]);
      if (s_rst[k]) begin
        #1;
        if (sel == 0) rst_a = 1'b0; else rst_b = 1'b0;
      end
    end
    s_op.delete();
    s_rdy.delete();
    s_exp.delete();
    s_rst.delete();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit expired");
    $fatal(1, "watchdog");
  end

  initial begin
    int n0, cnt;
    op = '0;
    rdy = 1'b0;
    rst_a = 1'b0;
    rst_b = 1'b0;
    #1 rst_b = 1'b1;

    // Configuration A: TIMEOUT=4, illegal continues, jump disabled.
    sel = 0; m_timeout = 4; m_ill_halt = 1'b0; m_en_jump = 1'b0;
    add_reset();
    add_instr(6'd0, 0, 0);
    n0 = s_exp.size();
    add_instr(6'd35, 0, 3);
    cnt = 0;
    for (int i = n0; i < s_exp.size(); i++) if (s_exp[i] == V_MEM_RD) cnt++;
    check_int("lw_memrd_cycles", cnt, 4);
    add_instr(6'd4, 0, 0);
    add_instr(6'd2, 0, 0);
    add_instr(6'd8, 4, 0);
    add_instr(6'd35, 0, 4);
    add_instr(6'd43, 1, 2, 1'b1);
    n0 = s_exp.size();
    add_instr(6'd0, 5, 0);
    check_int("timeout_err_index", s_exp.size() - n0, 6);
    add_halt_cycles(4);
    add_reset();
    add_random(40);
    run_schedule();
    rst_a = 1'b1;

    // Configuration B: no timeout, illegal halts, jump enabled.
    sel = 1; m_timeout = 0; m_ill_halt = 1'b1; m_en_jump = 1'b1;
    add_reset();
    lat("lat_r", 6'd0, 4);
    lat("lat_addi", 6'd8, 4);
    lat("lat_lw", 6'd35, 5);
    lat("lat_sw", 6'd43, 4);
    lat("lat_beq", 6'd4, 3);
    lat("lat_j", 6'd2, 3);
    add_instr(6'd0, 20, 0);
    add_instr(6'd35, 0, 25);
    add_instr(6'h3F, 0, 0);
    add_halt_cycles(3);
    add_reset();
    add_random(30);
    run_schedule();

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
